// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for one synchronous RAM port: round-robin with bounded bursts,
// registered RAM command, read-data return by tag. Define ARB_FIXED_PRIO_EN for fixed priority.
module ram_port_arbiter #(
  parameter int unsigned AW        = 8,
  parameter int unsigned DW        = 32,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic [1:0]    owner
);

  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic          rr_q, rr_d;
  logic [1:0]    owner_d;
  logic          burst_ok;

  logic          acc;
  logic          rd_acc;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  logic [RD_LAT:0] pipe_vld_q;
  logic [RD_LAT:0] pipe_id_q;

  assign burst_ok = burst_cnt_q < BW'(MAX_BURST);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
    gnt0 = req0;
    gnt1 = req1 & ~req0;
`else
    case (state_q)
      StIdle: begin
        if (req0 && req1) begin
          gnt0 = ~rr_q;
          gnt1 = rr_q;
        end else begin
          gnt0 = req0;
          gnt1 = req1;
        end
      end
      StOwn0: begin
        if (req0 && (burst_ok || !req1)) gnt0 = 1'b1;
        else if (req1)                   gnt1 = 1'b1;
      end
      StOwn1: begin
        if (req1 && (burst_ok || !req0)) gnt1 = 1'b1;
        else if (req0)                   gnt0 = 1'b1;
      end
      default: ;
    endcase
`endif
  end

  // rr_q = 1 favours req1 when both request from idle; set on a handover to point back
  always_comb begin
    state_d     = StIdle;
    burst_cnt_d = '0;
    rr_d        = rr_q;
    owner_d     = 2'b00;
    if (gnt0) begin
      state_d = StOwn0;
      owner_d = 2'b01;
      if (state_q == StOwn0) begin
        burst_cnt_d = burst_ok ? burst_cnt_q + BW'(1) : burst_cnt_q;
      end else begin
        burst_cnt_d = BW'(1);
      end
      if (state_q == StOwn1) rr_d = 1'b1;
    end else if (gnt1) begin
      state_d = StOwn1;
      owner_d = 2'b10;
      if (state_q == StOwn1) begin
        burst_cnt_d = burst_ok ? burst_cnt_q + BW'(1) : burst_cnt_q;
      end else begin
        burst_cnt_d = BW'(1);
      end
      if (state_q == StOwn0) rr_d = 1'b0;
    end
  end

  assign acc       = gnt0 | gnt1;
  assign sel_we    = gnt1 ? we1 : we0;
  assign sel_addr  = gnt1 ? addr1 : addr0;
  assign sel_wdata = gnt1 ? wdata1 : wdata0;
  assign rd_acc    = acc & ~sel_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      burst_cnt_q <= '0;
      rr_q        <= 1'b0;
      owner       <= 2'b00;
      ram_en      <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_din     <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      rr_q        <= rr_d;
      owner       <= owner_d;
      ram_en      <= acc;
      ram_we      <= acc & sel_we;
      if (acc) begin
        ram_addr <= sel_addr;
        ram_din  <= sel_wdata;
      end
    end
  end

  // Read tags ride alongside the RAM latency; id 1 marks a requester-1 read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld_q <= '0;
      pipe_id_q  <= '0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      pipe_vld_q <= {pipe_vld_q[RD_LAT-1:0], rd_acc};
      pipe_id_q  <= {pipe_id_q[RD_LAT-1:0], gnt1};
      rvalid0    <= pipe_vld_q[RD_LAT] & ~pipe_id_q[RD_LAT];
      rvalid1    <= pipe_vld_q[RD_LAT] & pipe_id_q[RD_LAT];
      if (pipe_vld_q[RD_LAT] && !pipe_id_q[RD_LAT]) rdata0 <= ram_dout;
      if (pipe_vld_q[RD_LAT] && pipe_id_q[RD_LAT])  rdata1 <= ram_dout;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Table-driven bench for ram_port_arbiter: per-cycle vectors with expected grants, plus a
// reference memory that predicts RAM commands, read returns and owner.
module tb_ram_port_arbiter;

  localparam int AW        = 8;
  localparam int DW        = 32;
  localparam int RD_LAT    = 1;
  localparam int MAX_BURST = 4;
  localparam int NC        = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic [1:0]    owner;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .owner(owner)
  );

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return (a == 8'd5) ? 32'h11 : ({4{a}} ^ 32'h5A5A0000);
  endfunction

  // Write-first synchronous RAM with RD_LAT cycles of read latency
  logic          mem_load = 1'b1;
  logic [DW-1:0] mem [256];
  logic [DW-1:0] dout_pipe [RD_LAT];
  assign ram_dout = dout_pipe[RD_LAT-1];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
      for (int i = 0; i < RD_LAT; i++) dout_pipe[i] <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) dout_pipe[i] <= dout_pipe[i-1];
      if (ram_en) begin
        if (ram_we) begin
          mem[ram_addr] <= ram_din;
          dout_pipe[0]  <= ram_din;
        end else begin
          dout_pipe[0] <= mem[ram_addr];
        end
      end
    end
  end

  typedef struct {
    logic          rs;
    logic          r0, w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          r1, w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          g0, g1;
  } vec_t;

  function automatic vec_t mk(input logic rs, input logic r0, input logic w0,
                              input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                              input logic r1, input logic w1,
                              input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                              input logic g0, input logic g1);
    vec_t v;
    v.rs = rs; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.g0 = g0; v.g1 = g1;
    return v;
  endfunction

  vec_t vecs[$];

  // Reference state
  logic [DW-1:0] ref_mem [256];
  logic          exp_en [NC];
  logic          exp_we [NC];
  logic [AW-1:0] exp_addr [NC];
  logic [DW-1:0] exp_din [NC];
  logic [1:0]    exp_own [NC];
  logic          exp_rv0 [NC];
  logic          exp_rv1 [NC];
  logic [DW-1:0] exp_rd0 [NC];
  logic [DW-1:0] exp_rd1 [NC];
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_din, last_rd0, last_rd1;
  int            cyc;
  int            n_cmp;
  int            n_err;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  task automatic clear_slot(input int i);
    exp_en[i] = 1'b0; exp_we[i] = 1'b0; exp_addr[i] = '0; exp_din[i] = '0;
    exp_own[i] = 2'b00; exp_rv0[i] = 1'b0; exp_rv1[i] = 1'b0;
    exp_rd0[i] = '0; exp_rd1[i] = '0;
  endtask

  // Called #1 after a rising edge; drives one cycle and checks it on the falling edge
  task automatic run_row(input vec_t v);
    logic          we_s;
    logic [AW-1:0] a_s;
    logic [DW-1:0] d_s;
    rst = v.rs;
    req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
    @(negedge clk);
    if (v.rs) begin
      for (int i = cyc; i < cyc + RD_LAT + 3; i++) clear_slot(i);
      last_addr = '0; last_din = '0; last_rd0 = '0; last_rd1 = '0;
    end
    if (exp_en[cyc]) begin
      last_addr = exp_addr[cyc];
      last_din  = exp_din[cyc];
    end
    if (exp_rv0[cyc]) last_rd0 = exp_rd0[cyc];
    if (exp_rv1[cyc]) last_rd1 = exp_rd1[cyc];
    chk("gnt0", 32'(gnt0), 32'(v.g0));
    chk("gnt1", 32'(gnt1), 32'(v.g1));
    chk("ram_en", 32'(ram_en), 32'(exp_en[cyc]));
    chk("ram_we", 32'(ram_we), 32'(exp_we[cyc]));
    chk("ram_addr", 32'(ram_addr), 32'(last_addr));
    chk("ram_din", ram_din, last_din);
    chk("owner", 32'(owner), 32'(exp_own[cyc]));
    chk("rvalid0", 32'(rvalid0), 32'(exp_rv0[cyc]));
    chk("rvalid1", 32'(rvalid1), 32'(exp_rv1[cyc]));
    chk("rdata0", rdata0, last_rd0);
    chk("rdata1", rdata1, last_rd1);
    if (!v.rs && (v.g0 || v.g1)) begin
      we_s = v.g1 ? v.w1 : v.w0;
      a_s  = v.g1 ? v.a1 : v.a0;
      d_s  = v.g1 ? v.d1 : v.d0;
      exp_en[cyc+1]   = 1'b1;
      exp_we[cyc+1]   = we_s;
      exp_addr[cyc+1] = a_s;
      exp_din[cyc+1]  = d_s;
      exp_own[cyc+1]  = v.g1 ? 2'b10 : 2'b01;
      if (we_s) begin
        ref_mem[a_s] = d_s;
      end else if (v.g1) begin
        exp_rv1[cyc+RD_LAT+2] = 1'b1;
        exp_rd1[cyc+RD_LAT+2] = ref_mem[a_s];
      end else begin
        exp_rv0[cyc+RD_LAT+2] = 1'b1;
        exp_rd0[cyc+RD_LAT+2] = ref_mem[a_s];
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) vecs.push_back(mk(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0,
                                                  1'b0, 1'b0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int n0, n1;
    logic g0e;
    n_cmp = 0; n_err = 0; cyc = 0;
    last_addr = '0; last_din = '0; last_rd0 = '0; last_rd1 = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    for (int i = 0; i < NC; i++) clear_slot(i);

    // Reset
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0));
    // Single read of RAM[5]
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'd5, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0));
    idle(4);
    // Write 200 then read it back
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 8'd200, 32'h7, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'd200, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0));
    idle(4);
    // Both requesting reads: bursts of MAX_BURST alternate
    n0 = 0; n1 = 0;
    for (int i = 0; i < 12; i++) begin
      g0e = ((i / MAX_BURST) % 2) == 0;
      vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'(10 + n0), '0, 1'b1, 1'b0, 8'(50 + n1), '0,
                        g0e, !g0e));
      if (g0e) n0++; else n1++;
    end
    idle(4);
`ifdef ARB_FIXED_PRIO_EN
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'd30, '0, 1'b1, 1'b0, 8'd31, '0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'd31, '0, 1'b0, 1'b1));
`else
    // rr now favours req1 after the last handover
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'd30, '0, 1'b1, 1'b0, 8'd31, '0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'd30, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0));
`endif
    idle(4);
    // req1 streams, req0 arrives during its burst with a write later read by req1
`ifdef ARB_FIXED_PRIO_EN
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'd100, '0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'd101, '0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 8'd60, 32'hDEADBEEF, 1'b1, 1'b0, 8'd102, '0,
                      1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'd102, '0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'd103, '0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'd60, '0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'd104, '0, 1'b0, 1'b1));
`else
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'd100, '0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'd101, '0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 8'd60, 32'hDEADBEEF, 1'b1, 1'b0, 8'd102, '0,
                      1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 8'd60, 32'hDEADBEEF, 1'b1, 1'b0, 8'd103, '0,
                      1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 8'd60, 32'hDEADBEEF, 1'b1, 1'b0, 8'd60, '0,
                      1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'd60, '0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'd104, '0, 1'b0, 1'b1));
`endif
    idle(4);
    // req1 write withdrawn before grant must not reach the RAM
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'd40, '0, 1'b1, 1'b1, 8'd77, 32'hBAD, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'd41, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0));
    idle(1);
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'd77, '0, 1'b0, 1'b1));
    // Long idle: read data retained
    idle(10);
    // Reset with three reads in flight
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'd20, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'd21, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'd22, '0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0));
    idle(4);
    // Recovery after reset
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'd5, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0));
    idle(4);

    @(posedge clk);
    #1;
    mem_load = 1'b0;
    foreach (vecs[i]) run_row(vecs[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
